// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction FIFO, 4x4 register file and
// three-state sequencer driving a combinational 4-bit ALU.
module alu_seq_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_instr,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       alu_enable,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_opcode,
  input  logic [3:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_rd,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wb;
  logic res_hs;

  logic [3:0] rf [4];
  logic [1:0] rd_q;

  logic [7:0] head;
  logic [1:0] head_op;
  logic [1:0] head_rd;
  logic [1:0] head_rs1;
  logic [1:0] head_rs2;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !empty;

  assign head = fifo_mem[rd_ptr];
  assign {head_op, head_rd, head_rs1, head_rs2} = head;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wb        = 1'b0;
    res_hs    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        wb        = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care once popped
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_instr;
    end
  end

  // FIFO pointers and occupancy; pop only sees entries
  // present before this edge, so there is no fall-through
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Register file; writeback is written last so it
  // overrides a host write to the same index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        rf[wr_addr] <= wr_data;
      end
      if (wb) begin
        rf[rd_q] <= alu_out;
      end
    end
  end

  // ALU operand launch and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_enable <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rd     <= '0;
    end else begin
      if (pop) begin
        alu_enable <= 1'b1;
        alu_a      <= rf[head_rs1];
        alu_b      <= rf[head_rs2];
        alu_opcode <= head_op;
        rd_q       <= head_rd;
      end
      if (wb) begin
        alu_enable <= 1'b0;
        res_valid  <= 1'b1;
        res_data   <= alu_out;
        res_rd     <= rd_q;
      end
      if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a
// behavioural ALU and register-file reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_instr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       alu_enable;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_hs = -1;
  bit gap_on  = 1'b0;

  logic [5:0] sb [$];
  logic [3:0] m_rf [4];

  alu_seq_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alu_enable (alu_enable),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .busy       (busy)
  );

  function automatic logic [3:0] alu_f(
    input logic [1:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] ins(
    input logic [1:0] op,
    input logic [1:0] rd,
    input logic [1:0] rs1,
    input logic [1:0] rs2
  );
    return {op, rd, rs1, rs2};
  endfunction

  assign alu_out = alu_f(alu_opcode, alu_a, alu_b);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic push_instr(input logic [7:0] i);
    int n;
    logic [3:0] r;
    n = 0;
    in_valid = 1'b1;
    in_instr = i;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("push_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
    r = alu_f(i[7:6], m_rf[i[3:2]], m_rf[i[1:0]]);
    m_rf[i[5:4]] = r;
    sb.push_back({i[5:4], r});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || res_valid || sb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  // Result monitor: every accepted result is matched against
  // the oldest scoreboard entry
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_data", res_data, e[3:0]);
          chk("res_rd", res_rd, e[5:4]);
          if (gap_on) begin
            if (last_hs >= 0) chk("res_gap", cyc - last_hs, 3);
            last_hs = cyc;
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] f;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_en", alu_enable, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_opcode, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    res_ready = 1'b1;

    // Basic add with latency and operand checks
    host_wr(2'd0, 4'd3);
    host_wr(2'd1, 4'd5);
    push_instr(ins(2'd0, 2'd2, 2'd0, 2'd1));
    chk("no_fallthru", alu_enable, 0);
    tick();
    chk("pop_en", alu_enable, 1);
    chk("pop_a", alu_a, 3);
    chk("pop_b", alu_b, 5);
    chk("pop_op", alu_opcode, 0);
    tick();
    chk("exec_en_low", alu_enable, 0);
    chk("exec_res_valid", res_valid, 1);
    wait_idle();
    chk("hold_a", alu_a, 3);
    push_instr(ins(2'd3, 2'd2, 2'd2, 2'd0));
    wait_idle();

    // Modulo-16 arithmetic
    host_wr(2'd0, 4'd2);
    host_wr(2'd1, 4'd5);
    push_instr(ins(2'd1, 2'd3, 2'd0, 2'd1));
    wait_idle();
    host_wr(2'd0, 4'd9);
    host_wr(2'd1, 4'd9);
    push_instr(ins(2'd0, 2'd2, 2'd0, 2'd1));
    wait_idle();
    host_wr(2'd0, 4'hC);
    host_wr(2'd1, 4'hA);
    push_instr(ins(2'd2, 2'd2, 2'd0, 2'd1));
    wait_idle();
    host_wr(2'd0, 4'd7);
    push_instr(ins(2'd3, 2'd1, 2'd0, 2'd0));
    wait_idle();

    // Back-pressure, FIFO fill and in-order drain
    res_ready = 1'b0;
    push_instr(ins(2'd0, 2'd3, 2'd0, 2'd1));
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("bp_valid_timeout", 1, 0);
    push_instr(ins(2'd3, 2'd0, 2'd1, 2'd0));
    push_instr(ins(2'd0, 2'd1, 2'd0, 2'd1));
    push_instr(ins(2'd1, 2'd2, 2'd3, 2'd0));
    push_instr(ins(2'd2, 2'd3, 2'd1, 2'd2));
    chk("full_in_ready", in_ready, 0);
    f = sb[0];
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, f[3:0]);
      chk("bp_rd", res_rd, f[5:4]);
      chk("bp_no_pop", alu_enable, 0);
      tick();
    end
    last_hs   = -1;
    gap_on    = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("drain_still_full", in_ready, 0);
    tick();
    chk("drain_ready_back", in_ready, 1);
    wait_idle();
    gap_on = 1'b0;

    // Dependency chain through R0
    host_wr(2'd0, 4'd1);
    for (int k = 0; k < 4; k++) push_instr(ins(2'd0, 2'd0, 2'd0, 2'd0));
    wait_idle();

    // Writeback versus host write at the same edge
    host_wr(2'd0, 4'd3);
    host_wr(2'd1, 4'd5);
    push_instr(ins(2'd0, 2'd2, 2'd0, 2'd1));
    tick();
    chk("coll_exec", alu_enable, 1);
    wr_en   = 1'b1;
    wr_addr = 2'd2;
    wr_data = 4'hF;
    tick();
    wr_en = 1'b0;
    wait_idle();
    push_instr(ins(2'd0, 2'd2, 2'd0, 2'd1));
    tick();
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 4'd6;
    tick();
    wr_en = 1'b0;
    m_rf[3] = 4'd6;
    wait_idle();
    push_instr(ins(2'd3, 2'd2, 2'd2, 2'd0));
    push_instr(ins(2'd3, 2'd3, 2'd3, 2'd0));
    wait_idle();

    // Reset during EXEC with two entries queued
    host_wr(2'd0, 4'd4);
    host_wr(2'd1, 4'd2);
    push_instr(ins(2'd0, 2'd2, 2'd0, 2'd1));
    push_instr(ins(2'd1, 2'd3, 2'd0, 2'd1));
    push_instr(ins(2'd2, 2'd1, 2'd0, 2'd1));
    push_instr(ins(2'd3, 2'd0, 2'd1, 2'd0));
    tick();
    chk("mid_exec_en", alu_enable, 1);
    rst = 1'b1;
    tick();
    sb.delete();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_en", alu_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_back", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      push_instr(ins(2'd3, 2'(i), 2'(i), 2'd0));
      wait_idle();
    end

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
